// File: rtl/hs_insert_if.sv
// hs_insert_if: game-over handshake and high-score RAM port bundle for hs_insert.
// The slave modport is the hs_insert side; the master modport is the game FSM / RAM side.
interface hs_insert_if #(
    parameter int SCORE_W = 32
);
    logic               start;
    logic [SCORE_W-1:0] score_in;
    logic [SCORE_W-1:0] ram_rdata;
    logic [1:0]         ram_raddr;
    logic [1:0]         ram_waddr;
    logic [SCORE_W-1:0] ram_wdata;
    logic               ram_we;
    logic               busy;
    logic               done;
    logic               inserted;

    modport slave (
        input  start,
        input  score_in,
        input  ram_rdata,
        output ram_raddr,
        output ram_waddr,
        output ram_wdata,
        output ram_we,
        output busy,
        output done,
        output inserted
    );

    modport master (
        output start,
        output score_in,
        output ram_rdata,
        input  ram_raddr,
        input  ram_waddr,
        input  ram_wdata,
        input  ram_we,
        input  busy,
        input  done,
        input  inserted
    );
endinterface

// File: rtl/hs_insert.sv
// hs_insert: upstream stage of the high-score sort.
// On start it reads the three high-score slots, finds the lowest (highest index on ties),
// overwrites it with the new score if the new score beats it, then pulses done.
// Optional build macro HS_INSERT_TIE_REPLACE_EN: an equal score also replaces the lowest slot,
// so the newest of equal scores is kept. Without it a strictly greater score is required.
// RD_LAT is the RAM read latency and must be 1 or 2.
module hs_insert #(
    parameter int SCORE_W = 32,
    parameter int RD_LAT  = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    hs_insert_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CMP,
        WR,
        DONE
    } state_t;

    // Address value meaning "no slot" on both RAM ports.
    localparam logic [1:0] NO_ADDR   = 2'b11;
    // Each slot address is held RD_LAT+1 cycles; data is captured on the last one.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT);

    state_t             state;
    logic [SCORE_W-1:0] new_q;
    logic [SCORE_W-1:0] slot0_q;
    logic [SCORE_W-1:0] slot1_q;
    logic [SCORE_W-1:0] slot2_q;
    logic [1:0]         k_q;
    logic [1:0]         wait_q;
    logic               hit_q;

    logic [1:0]         raddr_q;
    logic [1:0]         waddr_q;
    logic [SCORE_W-1:0] wdata_q;
    logic               we_q;
    logic               busy_q;
    logic               done_q;
    logic               inserted_q;

    logic [1:0]         min_idx_c;
    logic [SCORE_W-1:0] min_val_c;
    logic               hit_c;

    // Lowest stored slot, unsigned; "<=" lets a later equal slot win so ties pick the highest index.
    always_comb begin
        min_idx_c = 2'd0;
        min_val_c = slot0_q;
        if (slot1_q <= min_val_c) begin
            min_idx_c = 2'd1;
            min_val_c = slot1_q;
        end
        if (slot2_q <= min_val_c) begin
            min_idx_c = 2'd2;
            min_val_c = slot2_q;
        end
    end

`ifdef HS_INSERT_TIE_REPLACE_EN
    assign hit_c = (new_q >= min_val_c);
`else
    assign hit_c = (new_q > min_val_c);
`endif

    // Control FSM; every output is a register except the reset gate on the write enable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            new_q      <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            slot2_q    <= '0;
            k_q        <= 2'd0;
            wait_q     <= 2'd0;
            hit_q      <= 1'b0;
            raddr_q    <= NO_ADDR;
            waddr_q    <= NO_ADDR;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inserted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        new_q   <= bus.score_in;
                        k_q     <= 2'd0;
                        wait_q  <= 2'd0;
                        raddr_q <= 2'd0;
                        busy_q  <= 1'b1;
                        state   <= RD;
                    end
                end

                RD: begin
                    if (wait_q == WAIT_LAST) begin
                        case (k_q)
                            2'd0:    slot0_q <= bus.ram_rdata;
                            2'd1:    slot1_q <= bus.ram_rdata;
                            default: slot2_q <= bus.ram_rdata;
                        endcase
                        wait_q <= 2'd0;
                        if (k_q == 2'd2) begin
                            raddr_q <= NO_ADDR;
                            state   <= CMP;
                        end else begin
                            k_q     <= k_q + 2'd1;
                            raddr_q <= k_q + 2'd1;
                        end
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end

                CMP: begin
                    // waddr_q doubles as the registered min_idx for the write cycle.
                    hit_q   <= hit_c;
                    waddr_q <= min_idx_c;
                    wdata_q <= new_q;
                    we_q    <= hit_c;
                    state   <= WR;
                end

                WR: begin
                    waddr_q    <= NO_ADDR;
                    we_q       <= 1'b0;
                    done_q     <= 1'b1;
                    inserted_q <= hit_q;
                    state      <= DONE;
                end

                DONE: begin
                    done_q     <= 1'b0;
                    inserted_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    raddr_q    <= NO_ADDR;
                    waddr_q    <= NO_ADDR;
                    we_q       <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    inserted_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // The RAM samples the write on the same edge that applies Reset, so Reset must mask it
    // directly or an aborted request could still land its write.
    assign bus.ram_we    = we_q & ~Reset;
    assign bus.ram_raddr = raddr_q;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.inserted  = inserted_q;

endmodule

// File: tb/tb_hs_insert.sv
// tb_hs_insert: runs two hs_insert lanes side by side (RD_LAT=1 and RD_LAT=2), each with its
// own behavioural RAM, from shared start/score/Reset stimulus. A per-lane request-level model
// predicts every output each cycle; directed requests pin the model with literal expectations.
module tb_hs_insert;

    localparam int SCORE_W = 32;

    logic        Clk      = 1'b0;
    logic        Reset    = 1'b1;
    logic        start    = 1'b0;
    logic [31:0] score_in = '0;
    logic        preload  = 1'b0;
    logic [31:0] preload_vals [3];
    bit          chk_en   = 1'b0;
    int          errors   = 0;
    int          checks   = 0;

    wire [1:0]       o_busy, o_done, o_ins, o_we;
    wire [1:0]       e_busy, e_done, e_ins, e_we;
    wire [1:0][1:0]  o_raddr, o_waddr, e_raddr, e_waddr;
    wire [1:0][31:0] o_wdata, e_wdata;
    wire [1:0][95:0] o_mem;

    int          obsDone  [2];
    int          obsDone2 [2];
    int          obsWe    [2];
    logic [1:0]  obsWaddr [2][2];
    logic [31:0] obsWdata [2][2];
    logic        obsIns   [2];
    logic        obsBusyAfterRst [2];
    logic [1:0]  raddrSeq [16];

    always #5 Clk = ~Clk;

    // Index of the lowest score; when several share the minimum the highest index is chosen.
    function automatic logic [1:0] lowestSlot(input logic [31:0] s0, input logic [31:0] s1,
                                              input logic [31:0] s2);
        logic [31:0] lo;
        lo = s0;
        if (s1 < lo) lo = s1;
        if (s2 < lo) lo = s2;
        if (s2 == lo) return 2'd2;
        if (s1 == lo) return 2'd1;
        return 2'd0;
    endfunction

    // Whether a new score displaces the lowest stored score.
    function automatic bit beats(input logic [31:0] s, input logic [31:0] lo);
`ifdef HS_INSERT_TIE_REPLACE_EN
        return s >= lo;
`else
        return s > lo;
`endif
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L      = g + 1;
        localparam int RD_END = 3 * (L + 1);
        localparam int D      = RD_END + 3;

        hs_insert_if #(.SCORE_W(SCORE_W)) bus ();

        hs_insert #(.SCORE_W(SCORE_W), .RD_LAT(L)) dut (
            .Clk   (Clk),
            .Reset (Reset),
            .bus   (bus)
        );

        logic [31:0] mem  [4];
        logic [31:0] pipe [2];

        bit          m_busy = 1'b0;
        int          m_cyc  = 0;
        logic [31:0] m_s    = '0;
        logic [1:0]  m_min  = 2'd0;
        bit          m_hit  = 1'b0;

        assign bus.start     = start;
        assign bus.score_in  = score_in;
        assign bus.ram_rdata = pipe[L-1];

        // High-score RAM with an L-cycle registered read path.
        always @(posedge Clk) begin
            if (preload) begin
                mem[0] <= preload_vals[0];
                mem[1] <= preload_vals[1];
                mem[2] <= preload_vals[2];
                mem[3] <= '0;
            end else if (bus.ram_we) begin
                mem[bus.ram_waddr] <= bus.ram_wdata;
            end
            pipe[0] <= mem[bus.ram_raddr];
            pipe[1] <= pipe[0];
        end

        // Request-level model: on acceptance, decide the outcome from the RAM contents;
        // then just count cycles until the request's done cycle D.
        always @(posedge Clk) begin
            if (Reset) begin
                m_busy <= 1'b0;
            end else if (m_busy) begin
                if (m_cyc == D) m_busy <= 1'b0;
                else            m_cyc  <= m_cyc + 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_cyc  <= 1;
                m_s    <= score_in;
                m_min  <= lowestSlot(mem[0], mem[1], mem[2]);
                m_hit  <= beats(score_in, mem[lowestSlot(mem[0], mem[1], mem[2])]);
            end
        end

        assign e_busy[g]  = m_busy;
        assign e_done[g]  = m_busy && (m_cyc == D);
        assign e_ins[g]   = m_busy && (m_cyc == D) && m_hit;
        assign e_we[g]    = m_busy && (m_cyc == D - 1) && m_hit && !Reset;
        assign e_waddr[g] = (m_busy && (m_cyc == D - 1)) ? m_min : 2'b11;
        assign e_raddr[g] = (m_busy && (m_cyc <= RD_END)) ? 2'((m_cyc - 1) / (L + 1)) : 2'b11;
        assign e_wdata[g] = m_s;

        assign o_busy[g]  = bus.busy;
        assign o_done[g]  = bus.done;
        assign o_ins[g]   = bus.inserted;
        assign o_we[g]    = bus.ram_we;
        assign o_raddr[g] = bus.ram_raddr;
        assign o_waddr[g] = bus.ram_waddr;
        assign o_wdata[g] = bus.ram_wdata;
        assign o_mem[g]   = {mem[2], mem[1], mem[0]};
    end

    task automatic checkOutput(input string name, input int ln, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s rdlat%0d: got %0d, expected %0d", name, ln + 1, act, exp);
        end
    endtask

    // Every output of both lanes against the model for the current cycle.
    task automatic checkCycle();
        for (int g = 0; g < 2; g++) begin
            checkOutput("busy",     g, 32'(o_busy[g]),  32'(e_busy[g]));
            checkOutput("done",     g, 32'(o_done[g]),  32'(e_done[g]));
            checkOutput("inserted", g, 32'(o_ins[g]),   32'(e_ins[g]));
            checkOutput("ram_we",   g, 32'(o_we[g]),    32'(e_we[g]));
            checkOutput("ram_raddr", g, 32'(o_raddr[g]), 32'(e_raddr[g]));
            checkOutput("ram_waddr", g, 32'(o_waddr[g]), 32'(e_waddr[g]));
            if (e_we[g]) checkOutput("ram_wdata", g, o_wdata[g], e_wdata[g]);
        end
    endtask

    // One clock cycle: drive inputs shortly after the rising edge, check on the falling edge.
    task automatic applyStimulus(input bit st, input logic [31:0] sc, input bit rst);
        @(posedge Clk);
        #2;
        start    = st;
        score_in = sc;
        Reset    = rst;
        @(negedge Clk);
        if (chk_en) checkCycle();
    endtask

    task automatic loadRam(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        preload_vals[0] = a;
        preload_vals[1] = b;
        preload_vals[2] = c;
        preload = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        preload = 1'b0;
    endtask

    function automatic logic [31:0] slotOf(input int g, input int i);
        return o_mem[g][i*32 +: 32];
    endfunction

    // Start is high for cycles 0..hold-1; score_in is scrambled once start drops.
    task automatic runRequest(input logic [31:0] score, input int hold, input int rstCycle,
                              input int ncyc);
        for (int g = 0; g < 2; g++) begin
            obsDone[g] = -1;
            obsDone2[g] = -1;
            obsWe[g] = 0;
            obsIns[g] = 1'b0;
            obsBusyAfterRst[g] = 1'b1;
        end
        for (int c = 0; c < ncyc; c++) begin
            applyStimulus(c < hold, (c < hold) ? score : $urandom, c == rstCycle);
            for (int g = 0; g < 2; g++) begin
                if (o_done[g]) begin
                    if (obsDone[g] < 0) begin
                        obsDone[g] = c;
                        obsIns[g]  = o_ins[g];
                    end else if (obsDone2[g] < 0) begin
                        obsDone2[g] = c;
                    end
                end
                if (o_we[g]) begin
                    if (obsWe[g] < 2) begin
                        obsWaddr[g][obsWe[g]] = o_waddr[g];
                        obsWdata[g][obsWe[g]] = o_wdata[g];
                    end
                    obsWe[g]++;
                end
                if (c == rstCycle + 1) obsBusyAfterRst[g] = o_busy[g];
            end
            if (c < 16) raddrSeq[c] = o_raddr[0];
        end
    endtask

    initial begin
        logic [1:0] expSeq [8];
        expSeq = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

        applyStimulus(1'b0, '0, 1'b1);
        chk_en = 1'b1;
        applyStimulus(1'b1, 32'd77, 1'b1);
        checkOutput("rst_raddr", 0, 32'(o_raddr[0]), 32'd3);
        checkOutput("rst_waddr", 1, 32'(o_waddr[1]), 32'd3);
        checkOutput("rst_wdata", 0, o_wdata[0], 32'd0);
        checkOutput("rst_busy",  0, 32'(o_busy[0]), 32'd0);
        checkOutput("rst_done",  1, 32'(o_done[1]), 32'd0);

        // Insert into the lowest slot.
        loadRam(32'd500, 32'd300, 32'd100);
        runRequest(32'd250, 1, -1, 16);
        checkOutput("t1_we_count", 0, obsWe[0], 1);
        checkOutput("t1_waddr",    0, 32'(obsWaddr[0][0]), 32'd2);
        checkOutput("t1_wdata",    0, obsWdata[0][0], 32'd250);
        checkOutput("t1_done_cyc", 0, obsDone[0], 9);
        checkOutput("t1_inserted", 0, 32'(obsIns[0]), 32'd1);
        checkOutput("t1_done_cyc", 1, obsDone[1], 12);
        checkOutput("t1_slot2",    0, slotOf(0, 2), 32'd250);
        checkOutput("t1_slot2",    1, slotOf(1, 2), 32'd250);

        // Score too low.
        loadRam(32'd500, 32'd300, 32'd100);
        runRequest(32'd50, 1, -1, 16);
        checkOutput("t2_we_count", 0, obsWe[0], 0);
        checkOutput("t2_done_cyc", 0, obsDone[0], 9);
        checkOutput("t2_inserted", 0, 32'(obsIns[0]), 32'd0);
        checkOutput("t2_slot2",    0, slotOf(0, 2), 32'd100);

        // Equal to the lowest score.
        loadRam(32'd400, 32'd100, 32'd100);
        runRequest(32'd100, 1, -1, 16);
`ifdef HS_INSERT_TIE_REPLACE_EN
        checkOutput("t3_we_count", 0, obsWe[0], 1);
        checkOutput("t3_waddr",    0, 32'(obsWaddr[0][0]), 32'd2);
        checkOutput("t3_inserted", 0, 32'(obsIns[0]), 32'd1);
`else
        checkOutput("t3_we_count", 0, obsWe[0], 0);
        checkOutput("t3_inserted", 0, 32'(obsIns[0]), 32'd0);
`endif

        // All-zero RAM: read address sequence and tie-break to slot 2.
        loadRam(32'd0, 32'd0, 32'd0);
        runRequest(32'd7, 1, -1, 16);
        for (int i = 0; i < 8; i++) checkOutput("t4_raddr_seq", 0, 32'(raddrSeq[i]), 32'(expSeq[i]));
        checkOutput("t4_waddr", 0, 32'(obsWaddr[0][0]), 32'd2);
        checkOutput("t4_slot2", 0, slotOf(0, 2), 32'd7);

        // Reset mid-read aborts the request; a fresh request then completes.
        loadRam(32'd1, 32'd2, 32'd3);
        runRequest(32'd999, 1, 4, 16);
        checkOutput("t5_busy_after_rst", 0, 32'(obsBusyAfterRst[0]), 32'd0);
        checkOutput("t5_busy_after_rst", 1, 32'(obsBusyAfterRst[1]), 32'd0);
        checkOutput("t5_we_count", 0, obsWe[0], 0);
        checkOutput("t5_we_count", 1, obsWe[1], 0);
        checkOutput("t5_no_done",  0, obsDone[0], -1);
        checkOutput("t5_no_done",  1, obsDone[1], -1);
        runRequest(32'd999, 1, -1, 16);
        checkOutput("t5_retry_done", 0, obsDone[0], 9);
        checkOutput("t5_retry_slot0", 0, slotOf(0, 0), 32'd999);

        // Reset landing on the write cycle of the RD_LAT=1 lane must block the write.
        loadRam(32'd1, 32'd2, 32'd3);
        runRequest(32'd5, 1, 8, 16);
        checkOutput("t5b_we_count", 0, obsWe[0], 0);
        checkOutput("t5b_slot0",    0, slotOf(0, 0), 32'd1);

        // Start held high: back-to-back requests.
        loadRam(32'd10, 32'd20, 32'd30);
        runRequest(32'd600, 20, -1, 30);
        checkOutput("t6_done_cyc",  1, obsDone[1], 12);
        checkOutput("t6_done2_cyc", 1, obsDone2[1], 25);
        checkOutput("t6_we_count",  1, obsWe[1], 2);
        checkOutput("t6_waddr_1st", 1, 32'(obsWaddr[1][0]), 32'd0);
        checkOutput("t6_wdata_1st", 1, obsWdata[1][0], 32'd600);
        checkOutput("t6_waddr_2nd", 1, 32'(obsWaddr[1][1]), 32'd1);
        checkOutput("t6_slot1",     1, slotOf(1, 1), 32'd600);
        checkOutput("t6_done2_cyc", 0, obsDone2[0], 19);

        // Random traffic with small values to provoke ties, plus occasional resets.
        loadRam($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                          $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs_insert.md
# hs_insert

Upstream stage of the high-score sort. On a game-over pulse it reads the three high-score slots from the high-score RAM and finds the lowest. If the new game score beats that slot, it overwrites it. It then pulses `done` so the game FSM can launch the sort stage, which reorders the slots. It is the sole RAM writer while busy; the sort stage owns the RAM afterwards.

## Interface
Parameters:
- `SCORE_W`, 32: score width in bits; matches RAM data width.
- `RD_LAT`, 1: RAM read latency in cycles; legal values are 1 or 2.

Ports:
- `Clk`, in, 1: system clock; all logic is on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: game-over request; sampled in IDLE only.
- `score_in`, in, SCORE_W: final score of the finished game; latched when `start` is accepted.
- `ram_rdata`, in, SCORE_W: RAM read data.
- `ram_raddr`, out, 2: RAM read address.
- `ram_waddr`, out, 2: RAM write address.
- `ram_wdata`, out, SCORE_W: RAM write data.
- `ram_we`, out, 1: RAM write enable.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `inserted`, out, 1: valid with `done`; 1 means `score_in` was written.

## Operation
- States: IDLE, RD, CMP, WR, DONE.
- **IDLE**
  - `start`=1: latch `score_in` into `new_q`, clear slot index k=0 and wait counter, go to RD.
  - Otherwise stay in IDLE.
- **RD**
  - Drive `ram_raddr`=k for RD_LAT+1 cycles.
  - On the last of those cycles, capture `ram_rdata` into `slot_q[k]`.
  - k<2: k+1, stay in RD. k==2: go to CMP.
- **CMP**
  - `min_idx` = index of the smallest `slot_q`, compared unsigned.
  - On equal minima, pick the highest index.
  - Register `min_idx` and `hit`, where hit = `new_q` > `slot_q[min_idx]`. Go to WR.
- **WR**
  - `ram_waddr`=`min_idx`, `ram_wdata`=`new_q`, `ram_we`=`hit`. Single cycle. Go to DONE.
- **DONE**
  - `done`=1 and `inserted`=`hit`. Return to IDLE.
- `start` is ignored outside IDLE.
- `score_in` changes after acceptance are ignored.
- `ram_we` is high for at most one cycle per request, and only in WR.
- Comparisons are full SCORE_W unsigned; there is no saturation and no arithmetic.

## Timing
- Reset values: `ram_raddr`=2'b11, `ram_waddr`=2'b11, `ram_wdata`=0, `ram_we`=0, `busy`=0, `done`=0, `inserted`=0, state=IDLE.
- The idle and non-RD value of `ram_raddr` is 2'b11. The value of `ram_waddr` outside WR is 2'b11.
- Latency, with `start` sampled in cycle 0:
  - RD occupies cycles 1 .. 3(RD_LAT+1).
  - CMP follows, then WR.
  - `done` is high in cycle 3(RD_LAT+1)+3: cycle 9 for RD_LAT=1, cycle 12 for RD_LAT=2.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `start` is accepted in the cycle after `done`.
- Reset asserted in any state:
  - Next cycle the block is in IDLE with all outputs at reset values.
  - No write occurs, even if Reset coincides with WR.
  - No `done` is produced for the aborted request.
- If Reset and `start` are high together, Reset wins and the start is dropped.

## Configuration
- Macro: `HS_INSERT_TIE_REPLACE_EN`.
- Defined: hit = `new_q` >= `slot_q[min_idx]`. A score equal to the lowest stored score replaces it, so the newest equal score is kept.
- Undefined: hit = `new_q` > `slot_q[min_idx]`. Strictly greater is required; an equal score is discarded.

## Test plan
1. RAM={500,300,100}, `score_in`=250, RD_LAT=1 -> one cycle with `ram_we`=1, `ram_waddr`=2, `ram_wdata`=250; `done`=1 in cycle 9 with `inserted`=1.
2. RAM={500,300,100}, `score_in`=50 -> `ram_we` never asserted; `done` in cycle 9 with `inserted`=0.
3. RAM={400,100,100}, `score_in`=100:
   - Without macro: no write, `inserted`=0.
   - With `HS_INSERT_TIE_REPLACE_EN`: write of 100 to slot 2, `inserted`=1.
4. RAM={0,0,0}, `score_in`=7 -> write of 7 to slot 2; `ram_raddr` sequence 0,0,1,1,2,2 and then 2'b11.
5. Reset pulsed in cycle 4 of a `score_in`=999 request -> `busy`=0 the next cycle; no `ram_we`; no `done`. A fresh start with `score_in`=999 then completes normally.
6. RD_LAT=2, `start` held high for 20 cycles, `score_in`=600, RAM={10,20,30}:
   - Exactly one write, 600 to slot 0, with `done` in cycle 12.
   - A second request is accepted in cycle 13.
   - That second request finds min slot 1 (20) and writes 600 to slot 1.
